// File: rtl/io_cell_cfg_pkg.sv
// Shared constants and types for the IO cell configuration register bank.
// Address map offsets, CTRL/STATUS bit positions and the apply FSM states.
package io_cell_cfg_pkg;

  localparam logic [31:0] SHADOW_BASE = 32'h0000_0000;
  localparam logic [31:0] ACTIVE_BASE = 32'h0000_0100;
  localparam logic [31:0] CTRL_ADDR   = 32'h0000_0200;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0204;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_FF00;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_LOCK_BIT      = 1;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_PENDING_BIT = 1;
  localparam int STATUS_LOCK_BIT    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } apply_state_e;

  function automatic logic [5:0] word_index(input logic [31:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/io_cell_cfg_regs.sv
// APB register bank holding shadow/active per-pad configuration; a commit
// copies shadow to active one cell every APPLY_GAP cycles.
module io_cell_cfg_regs
  import io_cell_cfg_pkg::*;
#(
  parameter int                    CONF_WIDTH      = 5,
  parameter int                    NUMBER_OF_CELLS = 25,
  parameter logic [CONF_WIDTH-1:0] DEFAULT_CFG     = '0,
  parameter int                    APPLY_GAP       = 4,
  parameter int                    ADDR_WIDTH      = 12
) (
  input  logic                                  clk_internal,
  input  logic                                  reset_internal,
  input  logic                                  psel,
  input  logic                                  penable,
  input  logic                                  pwrite,
  input  logic [ADDR_WIDTH-1:0]                 paddr,
  input  logic [31:0]                           pwdata,
  output logic [31:0]                           prdata,
  output logic                                  pready,
  output logic                                  pslverr,
  output logic [NUMBER_OF_CELLS*CONF_WIDTH-1:0] cell_cfg,
  output logic                                  cfg_applied
);

  localparam int IDX_W = (NUMBER_OF_CELLS > 1) ? $clog2(NUMBER_OF_CELLS) : 1;
  localparam int GAP_W = $clog2(APPLY_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUMBER_OF_CELLS - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(APPLY_GAP - 1);

  logic [CONF_WIDTH-1:0] shadow_q [NUMBER_OF_CELLS];
  logic [CONF_WIDTH-1:0] active_q [NUMBER_OF_CELLS];
  logic                  lock_q;
  apply_state_e          state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  cfg_applied_q;

  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic [31:0]      addr_w;
  logic [5:0]       word_idx;
  logic [IDX_W-1:0] cell_sel;
  logic             in_range;
  logic             is_shadow, is_active, is_ctrl, is_status;
  logic             setup_phase, access_phase;
  logic             apply_done, busy_next, pending;
  logic             dec_err, dec_stall;
  logic [31:0]      dec_rdata;
  logic             wr_go, shadow_we, ctrl_we, commit_go, lock_set;
  logic             unused_pwdata_bits;

  assign addr_w    = 32'(paddr);
  assign word_idx  = word_index(addr_w);
  assign cell_sel  = IDX_W'(word_idx);
  assign in_range  = ({26'd0, word_idx} < 32'(NUMBER_OF_CELLS));
  assign is_shadow = ((addr_w & REGION_MASK) == SHADOW_BASE);
  assign is_active = ((addr_w & REGION_MASK) == ACTIVE_BASE);
  assign is_ctrl   = (addr_w == CTRL_ADDR);
  assign is_status = (addr_w == STATUS_ADDR);

  assign setup_phase  = psel & ~penable;
  assign access_phase = psel & penable;

  assign unused_pwdata_bits = ^pwdata[31:CONF_WIDTH];

  // The FSM is still applying next cycle unless the last cell is written now.
  assign apply_done = (state_q == APPLY) && (gap_q == '0) && (idx_q == LAST_IDX);
  assign busy_next  = (state_q == APPLY) && !apply_done;

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < NUMBER_OF_CELLS; i++) begin
      if (shadow_q[i] != active_q[i]) begin
        pending = 1'b1;
      end
    end
  end

  always_comb begin
    dec_err   = 1'b0;
    dec_stall = 1'b0;
    dec_rdata = '0;
    if (is_shadow && in_range) begin
      if (pwrite) begin
        dec_err   = lock_q;
        dec_stall = 1'b1;
      end else begin
        dec_rdata = 32'(shadow_q[cell_sel]);
      end
    end else if (is_active && in_range) begin
      if (pwrite) begin
        dec_err = 1'b1;
      end else begin
        dec_rdata = 32'(active_q[cell_sel]);
      end
    end else if (is_ctrl) begin
      if (pwrite) begin
        dec_err   = pwdata[CTRL_COMMIT_BIT] & lock_q;
        dec_stall = pwdata[CTRL_COMMIT_BIT];
      end else begin
        dec_rdata[CTRL_LOCK_BIT] = lock_q;
      end
    end else if (is_status) begin
      if (pwrite) begin
        dec_err = 1'b1;
      end else begin
        dec_rdata[STATUS_BUSY_BIT]    = (state_q == APPLY);
        dec_rdata[STATUS_PENDING_BIT] = pending;
        dec_rdata[STATUS_LOCK_BIT]    = lock_q;
      end
    end else begin
      dec_err = 1'b1;
    end
  end

  // Response is prepared during setup so it is already valid in the access cycle.
  always_comb begin
    prdata_d  = '0;
    pready_d  = 1'b1;
    pslverr_d = 1'b0;
    if (setup_phase) begin
      prdata_d  = dec_err ? 32'd0 : dec_rdata;
      pslverr_d = dec_err;
      pready_d  = !(dec_stall && !dec_err && busy_next);
    end else if (access_phase && !pready_q) begin
      pready_d = !busy_next;
    end
  end

  always_ff @(posedge clk_internal or negedge reset_internal) begin
    if (!reset_internal) begin
      prdata_q  <= '0;
      pready_q  <= 1'b1;
      pslverr_q <= 1'b0;
    end else begin
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign wr_go     = access_phase & pready_q & pwrite & ~pslverr_q;
  assign shadow_we = wr_go & is_shadow & in_range;
  assign ctrl_we   = wr_go & is_ctrl;
  assign commit_go = ctrl_we & pwdata[CTRL_COMMIT_BIT];
  assign lock_set  = ctrl_we & pwdata[CTRL_LOCK_BIT];

  always_ff @(posedge clk_internal or negedge reset_internal) begin
    if (!reset_internal) begin
      for (int i = 0; i < NUMBER_OF_CELLS; i++) begin
        shadow_q[i] <= DEFAULT_CFG;
      end
      lock_q <= 1'b0;
    end else begin
      if (shadow_we) begin
        shadow_q[cell_sel] <= pwdata[CONF_WIDTH-1:0];
      end
      if (lock_set) begin
        lock_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_internal or negedge reset_internal) begin
    if (!reset_internal) begin
      for (int i = 0; i < NUMBER_OF_CELLS; i++) begin
        active_q[i] <= DEFAULT_CFG;
      end
      state_q       <= IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      cfg_applied_q <= 1'b0;
    end else begin
      cfg_applied_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_go) begin
            state_q <= APPLY;
            idx_q   <= '0;
            gap_q   <= '0;
          end
        end
        APPLY: begin
          if (gap_q == '0) begin
            active_q[idx_q] <= shadow_q[idx_q];
            gap_q           <= GAP_RELOAD;
            if (idx_q == LAST_IDX) begin
              state_q       <= IDLE;
              cfg_applied_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUMBER_OF_CELLS; gi++) begin : g_cell_out
    assign cell_cfg[gi*CONF_WIDTH +: CONF_WIDTH] = active_q[gi];
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign cfg_applied = cfg_applied_q;

endmodule

// File: doc/io_cell_cfg_regs.md
Name: io_cell_cfg_regs

Overview:
- APB-accessible configuration register bank that drives the packed per-pad configuration bus consumed by the SoC IO cell frame; it is the writer side of cell_cfg.
- Software writes shadow registers, then commits them.
- A staggered apply engine copies shadow to active one cell at a time, which limits simultaneous pad reconfiguration.
- Sits in the IO subsystem, clocked by clk_internal, between the peripheral APB interconnect and the IO cell frame.

Parameters:
- CONF_WIDTH, 5, config bits per IO cell.
- NUMBER_OF_CELLS, 25, number of IO cells configured.
- DEFAULT_CFG, 5'b00000, reset value of every shadow and active entry (CONF_WIDTH bits).
- APPLY_GAP, 4, clk_internal cycles between successive cell updates during apply; legal range >= 1.
- ADDR_WIDTH, 12, APB address width.

Ports:
- clk_internal  input  1  clock.
- reset_internal  input  1  asynchronous, active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  ADDR_WIDTH  byte address, word aligned.
- pwdata  input  32  write data.
- prdata  output  32  read data.
- pready  output  1  transfer complete.
- pslverr  output  1  transfer error.
- cell_cfg  output  NUMBER_OF_CELLS*CONF_WIDTH  active config; cell i at bits [(i+1)*CONF_WIDTH-1 : i*CONF_WIDTH].
- cfg_applied  output  1  one-cycle pulse when an apply sequence finishes.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. Clock port is clk_internal; reset port is reset_internal.
- Reset values: all shadow and active entries = DEFAULT_CFG; lock=0; FSM=IDLE; prdata=0; pready=1; pslverr=0; cfg_applied=0.
- Address map (32-bit words):
  - 0x000+4i: SHADOW[i], RW, bits [CONF_WIDTH-1:0].
  - 0x100+4i: ACTIVE[i], RO.
  - 0x200: CTRL. bit0 COMMIT, W1, reads 0. bit1 LOCK, write-1 sticky until reset.
  - 0x204: STATUS, RO. bit0 BUSY (FSM=APPLY). bit1 PENDING (any shadow != active). bit2 LOCK.
  - Unused read bits return 0.
- APB handshake:
  - Setup phase = psel & ~penable; access phase = psel & penable.
  - Response is registered.
  - Reads complete in the first access cycle (pready=1), with prdata valid in that cycle.
  - Writes to SHADOW or CTRL.COMMIT while BUSY are held with pready=0 until the FSM returns to IDLE, then complete in that cycle.
- pslverr=1 (with pready=1, no state change) for:
  - i >= NUMBER_OF_CELLS;
  - unmapped address;
  - write to ACTIVE or STATUS;
  - SHADOW write or COMMIT while LOCK=1.
- A CTRL write with COMMIT=1 and LOCK=1 both set starts the commit, then sets the lock. The lock affects later transfers only.
- FSM IDLE to APPLY: triggered by an accepted COMMIT write; idx=0, gap=0.
- In APPLY, when gap==0:
  - ACTIVE[idx] <= SHADOW[idx] and gap <= APPLY_GAP-1.
  - If idx==NUMBER_OF_CELLS-1, go to IDLE; otherwise idx++.
- In APPLY, when gap!=0: gap--.
- Timing: cell k updates at cycle 1+k*APPLY_GAP after the COMMIT access cycle. cell_cfg reflects the update the cycle after.
- cfg_applied pulses for 1 cycle, in the cycle after the last cell update.
- Cells not yet reached keep their old active value. A SHADOW write cannot land during apply, because it is stalled.
- Widths: pwdata bits above CONF_WIDTH are ignored on write. idx is $clog2(NUMBER_OF_CELLS) bits; gap is $clog2(APPLY_GAP+1) bits.
- Reset mid-apply: everything returns to reset values immediately, and the apply is abandoned.
- psel deasserted mid-stall: protocol violation, undefined.

Decomposition:
- Package io_cell_cfg_pkg holds:
  - address offsets (SHADOW_BASE, ACTIVE_BASE, CTRL_ADDR, STATUS_ADDR);
  - CTRL/STATUS bit indices;
  - the FSM state typedef (IDLE, APPLY).
- No sub-module is needed. The APB decode and the apply FSM live in one module.

Test Plan:
- Reset -> cell_cfg = all DEFAULT_CFG; STATUS reads 0; pready=1.
- Write SHADOW[3]=5'h1A, read 0x00C -> 0x1A, ACTIVE[3] read -> 0x00, STATUS.PENDING=1 -> then COMMIT -> cell_cfg[19:15]=5'h1A at cycle 1+3*4=13 after commit; cfg_applied pulses at cycle 1+24*4+1=98; PENDING=0.
- Write SHADOW[0] during APPLY -> pready held low until BUSY clears, then write completes. The in-flight apply used the old SHADOW[0].
- CTRL write 0x2 (LOCK), then write SHADOW[1] and COMMIT -> both get pslverr=1, no change; STATUS.LOCK=1.
- Access 0x064 (i=25), 0x300, and write 0x104 -> pslverr=1, prdata=0, no state change.
- Assert reset_internal low at cycle 40 of an apply -> cell_cfg immediately all DEFAULT_CFG, BUSY=0, no cfg_applied pulse.
